// File: rtl/puf_vote_ctrl.sv
// puf_vote_ctrl: launches the arbiter PUF VOTES times per request, majority-votes each response bit, reports a stability mask.
// Latency: VOTES*(SETTLE+2) cycles from the accepting edge to rsp_valid; each evaluation is CLEAR(1) + ARM(SETTLE) + SAMPLE(1).
// Backpressure: req_ready only in IDLE; DONE holds the result and rsp_valid (puf_start low) until rsp_ready is seen.
module puf_vote_ctrl #(
    parameter int N      = 4,
    parameter int VOTES  = 7,
    parameter int SETTLE = 4,
    parameter int TUNE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N-1:0]      challenge1,
    input  logic [N-1:0]      challenge2,
    input  logic [TUNE_W-1:0] tune_level,
    output logic [N-1:0]      puf_ch1,
    output logic [N-1:0]      puf_ch2,
    output logic [TUNE_W-1:0] puf_tune,
    output logic              puf_start,
    input  logic [2*N-1:0]    puf_resp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*N-1:0]    response,
    output logic [2*N-1:0]    stable_mask,
    output logic              busy
);

    localparam int RW = 2 * N;
    localparam int CW = $clog2(VOTES + 1);
    localparam int SW = $clog2(SETTLE + 1);

    localparam logic [CW-1:0] HALF  = CW'(VOTES / 2);
    localparam logic [CW-1:0] VMAX  = CW'(VOTES);
    localparam logic [CW-1:0] ELAST = CW'(VOTES - 1);
    localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        SAMPLE,
        DONE
    } state_t;

    state_t        state;
    logic [RW-1:0] sync1;
    logic [RW-1:0] sync2;
    logic [CW-1:0] cnt     [RW];
    logic [CW-1:0] cnt_add [RW];
    logic [CW-1:0] eval_cnt;
    logic [SW-1:0] arm_cnt;

    assign req_ready = (state == IDLE);

    // Two-flop synchronizer for the asynchronous arbiter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= puf_resp;
            sync2 <= sync1;
        end
    end

    // Per-bit vote tally including the sample being taken this cycle; the
    // final SAMPLE uses it directly so the decision sees all VOTES samples.
    always_comb begin
        for (int i = 0; i < RW; i++) begin
            cnt_add[i] = cnt[i] + CW'(sync2[i]);
        end
    end

    // Sequencer: request latch, clear/arm/sample race loop, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            puf_start   <= 1'b0;
            puf_ch1     <= '0;
            puf_ch2     <= '0;
            puf_tune    <= '0;
            response    <= '0;
            stable_mask <= '0;
            rsp_valid   <= 1'b0;
            busy        <= 1'b0;
            eval_cnt    <= '0;
            arm_cnt     <= '0;
            for (int i = 0; i < RW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        puf_ch1   <= challenge1;
                        puf_ch2   <= challenge2;
                        puf_tune  <= tune_level;
                        eval_cnt  <= '0;
                        for (int i = 0; i < RW; i++) begin
                            cnt[i] <= '0;
                        end
                        busy      <= 1'b1;
                        puf_start <= 1'b0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    arm_cnt   <= '0;
                    puf_start <= 1'b1;
                    state     <= ARM;
                end
                ARM: begin
                    if (arm_cnt == SLAST) begin
                        state <= SAMPLE;
                    end else begin
                        arm_cnt <= arm_cnt + SW'(1);
                    end
                end
                SAMPLE: begin
                    for (int i = 0; i < RW; i++) begin
                        cnt[i] <= cnt_add[i];
                    end
                    eval_cnt  <= eval_cnt + CW'(1);
                    puf_start <= 1'b0;
                    if (eval_cnt == ELAST) begin
                        for (int i = 0; i < RW; i++) begin
                            response[i]    <= (cnt_add[i] > HALF);
                            stable_mask[i] <= (cnt_add[i] == '0) || (cnt_add[i] == VMAX);
                        end
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    puf_start <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
